// File: rtl/vga_scan_driver.sv
// VGA raster driver: pixel-rate divider, horizontal/vertical scan counters, and a registered sync/colour stage.
// Define VGA_BORDER_EN to force a one-pixel white frame around the active area.
module vga_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] color_data,
  output logic [9:0]  p_row,
  output logic [9:0]  p_col,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]       H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_sync_on;
  logic             v_sync_on;
  logic [11:0]      pixel_rgb;

  assign p_col      = h_cnt;
  assign p_row      = v_cnt;
  assign pixel_tick = (div_cnt == DIV_LAST);
  assign frame_tick = pixel_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign video_on   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_sync_on  = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
  assign v_sync_on  = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);

  // NOTE: default assignment first so every path drives pixel_rgb and no latch is inferred.
  always_comb begin
    pixel_rgb = 12'h000;
    if (video_on) begin
      pixel_rgb = color_data;
`ifdef VGA_BORDER_EN
      if (h_cnt == 10'd0 || h_cnt == 10'(H_ACTIVE - 1) ||
          v_cnt == 10'd0 || v_cnt == 10'(V_ACTIVE - 1)) begin
        pixel_rgb = 12'hFFF;
      end
`endif
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
    end else begin
      div_cnt <= pixel_tick ? '0 : div_cnt + 1'b1;
      if (pixel_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        // Output stage captures the pixel being left, giving one pixel period of latency.
        {vga_r, vga_g, vga_b} <= pixel_rgb;
        hsync <= ~h_sync_on;
        vsync <= ~v_sync_on;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver using a shrunken raster so whole frames fit in a short run.
// Expected colours follow VGA_BORDER_EN when the bench is compiled with it.
module tb_vga_scan_driver;

  localparam int D  = 3;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] color_data = '0;
  logic [9:0]  p_row, p_col;
  logic        video_on, pixel_tick, frame_tick, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_scan_driver #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color_data(color_data),
    .p_row(p_row), .p_col(p_col), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_tick(frame_tick),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // Reference model: raster position is pure arithmetic on clocks elapsed since reset release.
  function automatic int ref_h(input int unsigned n);
    return int'((n / D) % HT);
  endfunction

  function automatic int ref_v(input int unsigned n);
    return int'((n / (D * HT)) % VT);
  endfunction

  function automatic logic [11:0] ref_rgb(input int h, input int v, input logic [11:0] c);
    if (h >= HA || v >= VA) return 12'h000;
`ifdef VGA_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 12'hFFF;
`endif
    return c;
  endfunction

  int unsigned n     = 0;
  logic [11:0] m_rgb = '0;
  logic        m_hs  = 1'b1;
  logic        m_vs  = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     <= 0;
      m_rgb <= '0;
      m_hs  <= 1'b1;
      m_vs  <= 1'b1;
    end else begin
      if (n % D == D - 1) begin
        m_rgb <= ref_rgb(ref_h(n), ref_v(n), color_data);
        m_hs  <= !(ref_h(n) >= HA + HF && ref_h(n) < HA + HF + HS);
        m_vs  <= !(ref_v(n) >= VA + VF && ref_v(n) < VA + VF + VS);
      end
      n <= n + 1;
    end
  end

  // kind 0: pixel_tick at (h,v), negative = any; kind 1: frame_tick.
  task automatic wait_for(input int kind, input int h, input int v, output int cycles);
    logic hit;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (kind == 1) hit = frame_tick;
      else hit = pixel_tick && (h < 0 || int'(p_col) == h) && (v < 0 || int'(p_row) == v);
      if (hit) return;
      if (cycles > 2 * FRAME_CLK) begin
        checks++; errors++;
        $display("FAIL wait_timeout kind=%0d h=%0d v=%0d after %0d clk", kind, h, v, cycles);
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 8;
    if (p_row !== 10'd0)   begin errors++; $display("FAIL reset_p_row got %0d exp 0", p_row); end
    if (p_col !== 10'd0)   begin errors++; $display("FAIL reset_p_col got %0d exp 0", p_col); end
    if (video_on !== 1'b1) begin errors++; $display("FAIL reset_video_on got %b exp 1", video_on); end
    if (pixel_tick !== 1'b0) begin errors++; $display("FAIL reset_pixel_tick got %b exp 0", pixel_tick); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
    if (hsync !== 1'b1)    begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
    if (vsync !== 1'b1)    begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
    if (rgb !== 12'h000)   begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan(input int ncyc);
    int eh, ev;
    logic et, ef, evid;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      eh   = ref_h(n);
      ev   = ref_v(n);
      et   = (n % D == D - 1);
      ef   = et && eh == HT - 1 && ev == VT - 1;
      evid = eh < HA && ev < VA;
      checks += 8;
      if (int'(p_col) !== eh) begin errors++; $display("FAIL scan_p_col n=%0d got %0d exp %0d", n, p_col, eh); end
      if (int'(p_row) !== ev) begin errors++; $display("FAIL scan_p_row n=%0d got %0d exp %0d", n, p_row, ev); end
      if (pixel_tick !== et)  begin errors++; $display("FAIL scan_pixel_tick n=%0d got %b exp %b", n, pixel_tick, et); end
      if (frame_tick !== ef)  begin errors++; $display("FAIL scan_frame_tick n=%0d got %b exp %b", n, frame_tick, ef); end
      if (video_on !== evid)  begin errors++; $display("FAIL scan_video_on n=%0d got %b exp %b", n, video_on, evid); end
      if (hsync !== m_hs)     begin errors++; $display("FAIL scan_hsync n=%0d got %b exp %b", n, hsync, m_hs); end
      if (vsync !== m_vs)     begin errors++; $display("FAIL scan_vsync n=%0d got %b exp %b", n, vsync, m_vs); end
      if (rgb !== m_rgb)      begin errors++; $display("FAIL scan_rgb n=%0d got %h exp %h", n, rgb, m_rgb); end
      color_data = 12'($urandom);
    end
  endtask

  task automatic test_periods();
    int c;
    wait_for(0, -1, -1, c);
    wait_for(0, -1, -1, c);
    checks++;
    if (c !== D) begin errors++; $display("FAIL pixel_period got %0d exp %0d", c, D); end
    wait_for(0, HT - 1, -1, c);
    wait_for(0, HT - 1, -1, c);
    checks++;
    if (c !== HT * D) begin errors++; $display("FAIL line_period got %0d exp %0d", c, HT * D); end
    wait_for(1, -1, -1, c);
    @(negedge clk);
    checks += 3;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL frame_tick_width got %b exp 0", frame_tick); end
    if (p_col !== 10'd0) begin errors++; $display("FAIL wrap_p_col got %0d exp 0", p_col); end
    if (p_row !== 10'd0) begin errors++; $display("FAIL wrap_p_row got %0d exp 0", p_row); end
    wait_for(1, -1, -1, c);
    checks++;
    if (c + 1 !== FRAME_CLK) begin errors++; $display("FAIL frame_period got %0d exp %0d", c + 1, FRAME_CLK); end
  endtask

  task automatic test_sync();
    int c, hlow, vlow, first_col, first_row;
    hlow = 0; vlow = 0; first_col = -1; first_row = -1;
    wait_for(0, 0, 0, c);
    for (int i = 0; i < HT * VT; i++) begin
      wait_for(0, -1, -1, c);
      if (!hsync) begin
        hlow++;
        if (first_col < 0) begin first_col = int'(p_col); first_row = int'(p_row); end
      end
      if (!vsync) vlow++;
    end
    checks += 4;
    if (hlow !== HS * VT) begin errors++; $display("FAIL hsync_low_ticks got %0d exp %0d", hlow, HS * VT); end
    if (vlow !== VS * HT) begin errors++; $display("FAIL vsync_low_ticks got %0d exp %0d", vlow, VS * HT); end
    if (first_col !== HA + HF + 1) begin errors++; $display("FAIL hsync_fall_col got %0d exp %0d", first_col, HA + HF + 1); end
    if (first_row !== 0) begin errors++; $display("FAIL hsync_fall_row got %0d exp 0", first_row); end
  endtask

  task automatic test_color_points();
    int c;
    color_data = 12'hA5C;
    wait_for(0, 2, 2, c);
    @(negedge clk);
    checks++;
    if (rgb !== 12'hA5C) begin errors++; $display("FAIL color_active got %h exp a5c", rgb); end
    for (int i = 0; i < D - 1; i++) begin
      @(negedge clk);
      checks++;
      if (rgb !== 12'hA5C) begin errors++; $display("FAIL color_hold got %h exp a5c", rgb); end
    end
    wait_for(0, HA + 2, 2, c);
    @(negedge clk);
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL color_blank got %h exp 000", rgb); end
  endtask

  task automatic test_border();
    int c;
    int ph[5] = '{0, HA - 1, 2, 2, 2};
    int pv[5] = '{2, 2, 0, VA - 1, 2};
    logic [11:0] exp_c;
    color_data = 12'h000;
    for (int i = 0; i < 5; i++) begin
      wait_for(0, ph[i], pv[i], c);
      @(negedge clk);
      exp_c = ref_rgb(ph[i], pv[i], 12'h000);
      checks++;
      if (rgb !== exp_c) begin
        errors++; $display("FAIL border (%0d,%0d) got %h exp %h", ph[i], pv[i], rgb, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c, k;
    int rh, rv;
    rh = int'($urandom_range(HT - 1));
    rv = int'($urandom_range(VT - 1));
    color_data = 12'($urandom);
    wait_for(0, rh, rv, c);
    repeat (1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (p_row !== 10'd0 || p_col !== 10'd0) begin errors++; $display("FAIL midrst_pos got (%0d,%0d) exp (0,0)", p_col, p_row); end
    if (video_on !== 1'b1) begin errors++; $display("FAIL midrst_video_on got %b exp 1", video_on); end
    if (pixel_tick !== 1'b0) begin errors++; $display("FAIL midrst_pixel_tick got %b exp 0", pixel_tick); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_frame_tick got %b exp 0", frame_tick); end
    if (hsync !== 1'b1) begin errors++; $display("FAIL midrst_hsync got %b exp 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL midrst_vsync got %b exp 1", vsync); end
    if (rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb got %h exp 000", rgb); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Release at a falling edge: the divider reads 0 for the rest of clk 1, so the tick lands D-1 edges later.
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checks++;
        if (p_row !== 10'd0 || p_col !== 10'd0) begin errors++; $display("FAIL release_pos got (%0d,%0d) exp (0,0)", p_col, p_row); end
      end
    end while (!pixel_tick && k < 4 * D);
    checks++;
    if (k !== D - 1) begin errors++; $display("FAIL first_tick_edges got %0d exp %0d", k, D - 1); end
  endtask

  initial begin
    test_reset();
    test_scan(2 * FRAME_CLK + 200);
    test_periods();
    test_sync();
    test_color_points();
    test_border();
    test_reset_mid_frame();
    test_scan(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, giving pixel counts per line segment.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving line counts per frame segment.
REQ-004 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port color_data, input, 12, pixel colour {R[11:8],G[7:4],B[3:0]} for the current p_row/p_col.
REQ-007 SHALL have port p_row, output, 10, current vertical count (top line = 0).
REQ-008 SHALL have port p_col, output, 10, current horizontal count (left pixel = 0).
REQ-009 SHALL have port video_on, output, 1, high when p_row/p_col lie inside the active area.
REQ-010 SHALL have port pixel_tick, output, 1, one-clk pulse marking each pixel period.
REQ-011 SHALL have port frame_tick, output, 1, one-clk pulse at end of frame.
REQ-012 SHALL have ports hsync and vsync, output, 1 each, registered active-low syncs.
REQ-013 SHALL have ports vga_r, vga_g and vga_b, output, 4 each, registered colour.

Function
REQ-014 Divider SHALL count 0..CLK_DIV-1 and wrap; pixel_tick SHALL be high only in the cycle where the divider equals CLK_DIV-1.
REQ-015 h_cnt SHALL advance only on pixel_tick and SHALL wrap from H_TOTAL-1 (799) to 0; H_TOTAL is the sum of the four H parameters.
REQ-016 v_cnt SHALL advance only on pixel_tick with h_cnt = 799 and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-017 p_col SHALL equal h_cnt and p_row SHALL equal v_cnt, driven directly from the registers.
REQ-018 video_on SHALL be combinational: (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-019 Sync SHALL be asserted low when h_cnt is in [656,751] (hsync) or v_cnt is in [490,491] (vsync); bounds SHALL derive from the parameters.
REQ-020 Output stage SHALL load on pixel_tick only: rgb takes color_data when video_on, else 0; hsync and vsync take the sync values for the same h_cnt/v_cnt.
REQ-021 Output stage latency SHALL be exactly one pixel period; rgb, hsync and vsync SHALL remain mutually aligned.
REQ-022 frame_tick SHALL pulse for one clk when pixel_tick, h_cnt = 799 and v_cnt = 524 coincide.
REQ-023 Outputs SHALL hold steady between pixel_ticks.
REQ-024 color_data SHALL be ignored outside the active area.

Reset
REQ-025 While rst_n is low, the divider, h_cnt and v_cnt SHALL be 0, with p_row = p_col = 0 and video_on = 1.
REQ-026 While rst_n is low, pixel_tick = 0, frame_tick = 0, hsync = vsync = 1 and vga_r = vga_g = vga_b = 0.
REQ-027 Reset asserted mid-frame SHALL take effect immediately; after release, scanning SHALL restart at (0,0) and the first pixel_tick SHALL occur on the CLK_DIV-th clk.

Configuration
REQ-028 With macro VGA_BORDER_EN defined, active pixels with h_cnt in {0, H_ACTIVE-1} or v_cnt in {0, V_ACTIVE-1} SHALL output 12'hFFF regardless of color_data.
REQ-029 Without VGA_BORDER_EN, no border SHALL be drawn and every active pixel SHALL output color_data.

Verification
REQ-030 Release reset and count clks -> pixel_tick period = 4 clk; line = 3200 clk; frame_tick period = 1,680,000 clk.
REQ-031 Observe hsync over one line -> low for exactly 96 pixel_ticks, its falling edge one pixel period after h_cnt reaches 656; vsync low for 2 lines.
REQ-032 Drive color_data = 12'hA5C; sample the output at h_cnt = 10, v_cnt = 10 and at h_cnt = 700 -> rgb = A,5,C one pixel later at h_cnt = 10; rgb = 0 at h_cnt = 700.
REQ-033 Assert rst_n low at v_cnt = 300, h_cnt = 400 -> all outputs at reset values immediately; after release, p_row = p_col = 0.
REQ-034 Hold color_data = 0 with VGA_BORDER_EN defined -> rgb = FFF at (0,5), (639,5), (5,0) and (5,479); rgb = 0 at (5,5). Without the macro -> rgb = 0 at all of these points.
REQ-035 Run across the frame wrap -> frame_tick pulses once; the next pixel shows p_row = 0, p_col = 0.
